// File: rtl/uart_word_tx_fifo.sv
// Word FIFO between the EX-stage RegtoUART path and the UART byte sender.
// Each queued word is split into 1..WORD_WIDTH/8 bytes, one per ready/enable handshake.
module uart_word_tx_fifo #(
    parameter int WORD_WIDTH = 32,
    parameter int DEPTH_LOG2 = 3,
    parameter bit MSB_FIRST  = 1'b1
) (
    input  logic                            CLK,
    input  logic                            reset,
    input  logic [WORD_WIDTH-1:0]           wr_data,
    input  logic [$clog2(WORD_WIDTH/8):0]   wr_bytes,
    input  logic                            wr_enable,
    input  logic                            sender_ready,
    output logic [7:0]                      sender_data,
    output logic                            sender_enable,
    output logic                            full,
    output logic                            empty,
    output logic [DEPTH_LOG2:0]             count,
    output logic                            overflow,
    input  logic                            clear_overflow
);

    localparam int NB    = WORD_WIDTH / 8;
    localparam int BW    = $clog2(NB) + 1;
    localparam int DEPTH = 1 << DEPTH_LOG2;

    localparam logic [DEPTH_LOG2:0] DEPTH_C = (DEPTH_LOG2 + 1)'(DEPTH);
    localparam logic [BW-1:0]       NB_C    = BW'(NB);

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        WAIT_BUSY
    } state_t;

    state_t state;

    logic [WORD_WIDTH-1:0] mem_word  [DEPTH];
    logic [BW-1:0]         mem_bytes [DEPTH];

    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2-1:0] rd_ptr;
    logic [DEPTH_LOG2:0]   count_next;

    logic [WORD_WIDTH-1:0] shreg;
    logic [WORD_WIDTH-1:0] shreg_next;
    logic [WORD_WIDTH-1:0] load_word;
    logic [BW-1:0]         head_n;
    logic [BW-1:0]         remaining;
    logic [1:0]            timer;
    logic [7:0]            cur_byte;

    logic push;
    logic pop;
    logic wait_done;
    int   shamt;

    assign push      = wr_enable && !full;
    assign wait_done = !sender_ready || (timer == 2'd3);
    assign empty     = (count == '0) && (state == IDLE);

    // Head-of-queue decode: a byte count of zero means the whole word.
    always_comb begin
        head_n = mem_bytes[rd_ptr];
        if (head_n == '0) begin
            head_n = NB_C;
        end
        shamt = 8 * (NB - int'(head_n));
        if (MSB_FIRST) begin
            load_word = mem_word[rd_ptr] << shamt;
        end else begin
            load_word = mem_word[rd_ptr];
        end
    end

    always_comb begin
        if (MSB_FIRST) begin
            cur_byte   = shreg[WORD_WIDTH-1 -: 8];
            shreg_next = shreg << 8;
        end else begin
            cur_byte   = shreg[7:0];
            shreg_next = shreg >> 8;
        end
    end

    always_comb begin
        pop = 1'b0;
        unique case (state)
            IDLE:      pop = (count != '0);
            WAIT_BUSY: pop = wait_done && (remaining == '0) && (count != '0);
            default:   pop = 1'b0;
        endcase
    end

    always_comb begin
        count_next = count;
        unique case ({push, pop})
            2'b10:   count_next = count + 1'b1;
            2'b01:   count_next = count - 1'b1;
            default: count_next = count;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (push) begin
            mem_word[wr_ptr]  <= wr_data;
            mem_bytes[wr_ptr] <= wr_bytes;
        end
    end

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            full     <= 1'b0;
            overflow <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count_next;
            full  <= (count_next == DEPTH_C);
            // A dropped push outranks a clear in the same cycle.
            if (wr_enable && full) begin
                overflow <= 1'b1;
            end else if (clear_overflow) begin
                overflow <= 1'b0;
            end
        end
    end

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            state         <= IDLE;
            shreg         <= '0;
            remaining     <= '0;
            timer         <= '0;
            sender_data   <= '0;
            sender_enable <= 1'b0;
        end else begin
            sender_enable <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (pop) begin
                        shreg     <= load_word;
                        remaining <= head_n;
                        state     <= SEND;
                    end
                end
                SEND: begin
                    if (sender_ready) begin
                        sender_data   <= cur_byte;
                        sender_enable <= 1'b1;
                        shreg         <= shreg_next;
                        remaining     <= remaining - 1'b1;
                        timer         <= '0;
                        state         <= WAIT_BUSY;
                    end
                end
                WAIT_BUSY: begin
                    // Move on once the sender goes busy, or after four cycles regardless.
                    if (wait_done) begin
                        if (remaining != '0) begin
                            state <= SEND;
                        end else if (pop) begin
                            shreg     <= load_word;
                            remaining <= head_n;
                            state     <= SEND;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        timer <= timer + 2'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_word_tx_fifo.sv
// Bench for uart_word_tx_fifo: an MSB-first and an LSB-first instance share stimulus
// and are compared against byte queues built from the word/byte-count rules.
module tb_uart_word_tx_fifo;

    logic        CLK;
    logic        reset;
    logic [31:0] wr_data;
    logic [2:0]  wr_bytes;
    logic        wr_enable;
    logic        sender_ready;
    logic        clear_overflow;

    logic [7:0]  data_m, data_l;
    logic        en_m, en_l;
    logic        full_m, full_l;
    logic        empty_m, empty_l;
    logic [3:0]  count_m, count_l;
    logic        ovf_m, ovf_l;

    int passed = 0;
    int total  = 0;

    logic [7:0] exp_m[$], exp_l[$];
    logic [7:0] got_m[$], got_l[$];

    bit hold = 0;
    int busy_left = 0;
    int dbl = 0;
    int max_count = 0;
    bit prev_en = 0;

    uart_word_tx_fifo #(.WORD_WIDTH(32), .DEPTH_LOG2(3), .MSB_FIRST(1'b1)) dut_m (
        .CLK(CLK), .reset(reset), .wr_data(wr_data), .wr_bytes(wr_bytes),
        .wr_enable(wr_enable), .sender_ready(sender_ready),
        .sender_data(data_m), .sender_enable(en_m), .full(full_m),
        .empty(empty_m), .count(count_m), .overflow(ovf_m),
        .clear_overflow(clear_overflow)
    );

    uart_word_tx_fifo #(.WORD_WIDTH(32), .DEPTH_LOG2(3), .MSB_FIRST(1'b0)) dut_l (
        .CLK(CLK), .reset(reset), .wr_data(wr_data), .wr_bytes(wr_bytes),
        .wr_enable(wr_enable), .sender_ready(sender_ready),
        .sender_data(data_l), .sender_enable(en_l), .full(full_l),
        .empty(empty_l), .count(count_l), .overflow(ovf_l),
        .clear_overflow(clear_overflow)
    );

    initial CLK = 0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Reference: a word with n bytes contributes its low n bytes in send order.
    task automatic add_exp(input logic [31:0] w, input logic [2:0] b);
        int n;
        n = (b == 0) ? 4 : int'(b);
        for (int i = 0; i < n; i++) exp_l.push_back(w[8*i +: 8]);
        for (int i = n - 1; i >= 0; i--) exp_m.push_back(w[8*i +: 8]);
    endtask

    task automatic push(input logic [31:0] w, input logic [2:0] b, input bit accept);
        wr_data   = w;
        wr_bytes  = b;
        wr_enable = 1;
        @(negedge CLK);
        wr_enable = 0;
        if (accept) add_exp(w, b);
    endtask

    task automatic drain(input string tag);
        int guard;
        guard = 0;
        while (!(empty_m && empty_l) && guard < 2000) begin
            @(negedge CLK);
            guard++;
        end
        check({tag, "_drain_done"}, guard < 2000, 1);
        repeat (3) @(negedge CLK);
    endtask

    task automatic compare(input string tag);
        logic [7:0] g;
        check({tag, "_nbytes_m"}, got_m.size(), exp_m.size());
        check({tag, "_nbytes_l"}, got_l.size(), exp_l.size());
        for (int i = 0; i < exp_m.size(); i++) begin
            g = (i < got_m.size()) ? got_m[i] : 8'hxx;
            check($sformatf("%s_m_byte%0d", tag, i), g, exp_m[i]);
        end
        for (int i = 0; i < exp_l.size(); i++) begin
            g = (i < got_l.size()) ? got_l[i] : 8'hxx;
            check($sformatf("%s_l_byte%0d", tag, i), g, exp_l[i]);
        end
        exp_m.delete(); exp_l.delete();
        got_m.delete(); got_l.delete();
    endtask

    // Sender model: goes busy for 0..3 cycles after each strobe.
    initial begin
        sender_ready = 1;
        forever begin
            @(negedge CLK);
            if (en_m) begin
                got_m.push_back(data_m);
                if (prev_en) dbl++;
            end
            if (en_l) got_l.push_back(data_l);
            prev_en = en_m;
            if (int'(count_m) > max_count) max_count = int'(count_m);
            if (hold) begin
                sender_ready = 0;
            end else if (en_m) begin
                busy_left = $urandom_range(0, 3);
                sender_ready = (busy_left == 0);
            end else if (busy_left > 0) begin
                busy_left--;
                sender_ready = (busy_left == 0);
            end else begin
                sender_ready = 1;
            end
        end
    end

    initial begin
        int lat;
        int guard;
        logic [31:0] w;
        logic [2:0]  b;

        reset = 0;
        wr_data = 0;
        wr_bytes = 0;
        wr_enable = 0;
        clear_overflow = 0;

        // 1. reset then idle
        repeat (3) @(negedge CLK);
        check("rst_empty", {empty_m, empty_l}, 2'b11);
        check("rst_en", {en_m, en_l}, 2'b00);
        check("rst_data", data_m, 8'h00);
        reset = 1;
        repeat (5) @(negedge CLK);
        check("idle_empty", {empty_m, empty_l}, 2'b11);
        check("idle_full", {full_m, full_l}, 2'b00);
        check("idle_count", count_m, 4'd0);
        check("idle_ovf", {ovf_m, ovf_l}, 2'b00);
        check("idle_no_strobe", got_m.size() + got_l.size(), 0);

        // 2. single full word
        push(32'h11223344, 3'd4, 1);
        lat = 0;
        while (!en_m && lat < 20) begin
            @(negedge CLK);
            lat++;
        end
        check("latency_ge2", (lat >= 2) && (lat < 20), 1);
        drain("single");
        compare("single");
        check("single_empty", {empty_m, empty_l}, 2'b11);

        // 3. partial word and zero byte count
        push(32'hAABBCCDD, 3'd2, 1);
        drain("partial");
        compare("partial");
        push(32'hAABBCCDD, 3'd0, 1);
        drain("bytes0");
        compare("bytes0");

        // 4. fill with sender held: word 1 sits in flight, 2..9 fill the queue
        hold = 1;
        repeat (2) @(negedge CLK);
        for (int k = 1; k <= 9; k++) push(32'(k), 3'd4, 1);
        check("fill_count", count_m, 4'd8);
        check("fill_full", {full_m, full_l}, 2'b11);
        check("fill_not_empty", empty_m, 1'b0);
        check("fill_ovf_pre", ovf_m, 1'b0);
        push(32'd10, 3'd4, 0);
        check("ovf_set", {ovf_m, ovf_l}, 2'b11);
        check("ovf_count", count_m, 4'd8);
        clear_overflow = 1;
        @(negedge CLK);
        clear_overflow = 0;
        check("ovf_clear", ovf_m, 1'b0);
        clear_overflow = 1;
        push(32'd11, 3'd4, 0);
        clear_overflow = 0;
        check("ovf_set_wins", ovf_m, 1'b1);
        hold = 0;
        drain("fill");
        compare("fill");
        check("ovf_sticky", ovf_m, 1'b1);
        clear_overflow = 1;
        @(negedge CLK);
        clear_overflow = 0;
        check("ovf_cleared", {ovf_m, ovf_l}, 2'b00);

        // 5. random stream across pointer wrap; the core stalls while full
        max_count = 0;
        for (int i = 0; i < 20; i++) begin
            guard = 0;
            while (full_m && guard < 1000) begin
                @(negedge CLK);
                guard++;
            end
            w = $urandom;
            b = 3'($urandom_range(0, 4));
            push(w, b, 1);
            repeat (2) @(negedge CLK);
        end
        drain("stream");
        compare("stream");
        check("stream_max_count", max_count <= 8, 1);
        check("stream_no_ovf", {ovf_m, ovf_l}, 2'b00);

        // 6. reset mid-transfer
        push(32'h11223344, 3'd4, 1);
        guard = 0;
        while (got_m.size() < 2 && guard < 200) begin
            @(negedge CLK);
            guard++;
        end
        check("mid_two_bytes", got_m.size(), 2);
        #2 reset = 0;
        #1;
        check("mid_rst_en", {en_m, en_l}, 2'b00);
        check("mid_rst_data", {data_m, data_l}, 16'h0000);
        check("mid_rst_empty", {empty_m, empty_l}, 2'b11);
        check("mid_rst_count", count_m, 4'd0);
        repeat (2) @(negedge CLK);
        reset = 1;
        repeat (20) @(negedge CLK);
        check("mid_no_residual_m", got_m.size(), 2);
        check("mid_no_residual_l", got_l.size(), 2);
        exp_m.delete(); exp_l.delete();
        got_m.delete(); got_l.delete();
        push(32'h55667788, 3'd4, 1);
        drain("fresh");
        compare("fresh");

        check("strobe_one_cycle", dbl, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
